// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
//   Decodes the D-stage MIPS instruction into a control bundle and registers
//   it into the ID/EX boundary. It detects load-use hazards and inserts
//   LOAD_DELAY bubbles. It honours a downstream freeze and a taken
//   branch/jump flush. It tracks undefined instructions with a sticky flag
//   and a saturating counter.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   instr_d, valid_d    D-stage instruction and its valid flag
//   freeze              downstream hold: E register, FSM and counters keep state
//   flush_e             taken branch/jump: squash the D-stage instruction
//   stall_fd            hold PC and IF/ID register
//   valid_e, *_e        registered control bundle for the E stage
//   illegal_e           E-stage instruction was undefined
//   ill_sticky, ill_cnt undefined-instruction flag and saturating count
//
// Handshake: there is no ready/valid back-pressure. valid_d qualifies
// instr_d. stall_fd tells the fetch side to present the same instruction
// again. freeze overrides everything and holds every register.
//
// ALU control code map:
//   add 0, addu 1, sub 2, subu 3, and 4, nor 5, or 6, xor 7, sll 8,
//   sllv 9, srl 10, srlv 11, sra 12, srav 13, slt 14, jr 15, addi 16,
//   addiu 17, andi 18, ori 19, xori 20, beq 21, bne 22, lw 23, sw 24,
//   j 25, jal 26
module decode_ctrl_pipe #(
    parameter int ALU_CTRL_W = 5,
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_DELAY = 1,
    parameter int ILL_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_d,
    input  logic                  valid_d,
    input  logic                  freeze,
    input  logic                  flush_e,
    output logic                  stall_fd,
    output logic                  valid_e,
    output logic                  reg_write_e,
    output logic                  mem_to_reg_e,
    output logic                  mem_write_e,
    output logic                  mem_read_e,
    output logic                  branch_e,
    output logic                  alu_src_e,
    output logic                  reg_dst_e,
    output logic                  sign_ext_e,
    output logic                  shamt_e,
    output logic                  r_type_e,
    output logic                  sw_e,
    output logic [2:0]            pc_sel_e,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
    output logic [REG_ADDR_W-1:0] rs_e,
    output logic [REG_ADDR_W-1:0] rt_e,
    output logic [REG_ADDR_W-1:0] rd_e,
    output logic                  illegal_e,
    output logic                  ill_sticky,
    output logic [ILL_CNT_W-1:0]  ill_cnt
);

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  mem_read;
        logic                  branch;
        logic                  alu_src;
        logic                  reg_dst;
        logic                  sign_ext;
        logic                  shamt;
        logic                  r_type;
        logic                  sw;
        logic [2:0]            pc_sel;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic                  illegal;
    } ctrl_t;

    typedef enum logic [0:0] {ST_RUN, ST_STALL} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_nxt;
    ctrl_t                 r_e;
    ctrl_t                 w_dec;
    logic                  r_valid_e;
    logic [REG_ADDR_W-1:0] r_rs_e;
    logic [REG_ADDR_W-1:0] r_rt_e;
    logic [REG_ADDR_W-1:0] r_rd_e;
    logic                  r_ill_sticky;
    logic [ILL_CNT_W-1:0]  r_ill_cnt;

    logic [5:0]            w_op;
    logic [5:0]            w_funct;
    logic [REG_ADDR_W-1:0] w_rs_d;
    logic [REG_ADDR_W-1:0] w_rt_d;
    logic [REG_ADDR_W-1:0] w_rd_d;
    logic                  w_uses_rt;
    logic                  w_hazard;
    logic                  w_load_dec;
    logic                  w_unused;

    assign w_op     = instr_d[31:26];
    assign w_funct  = instr_d[5:0];
    assign w_rs_d   = REG_ADDR_W'(instr_d[25:21]);
    assign w_rt_d   = REG_ADDR_W'(instr_d[20:16]);
    assign w_rd_d   = REG_ADDR_W'(instr_d[15:11]);
    assign w_unused = ^instr_d[10:6];

    // Instruction decode
    always_comb begin
        w_dec = '0;
        case (w_op)
            6'h00: begin
                w_dec.reg_dst   = 1'b1;
                w_dec.r_type    = 1'b1;
                w_dec.reg_write = 1'b1;
                case (w_funct)
                    6'h20: w_dec.alu_ctrl = ALU_CTRL_W'(0);
                    6'h21: w_dec.alu_ctrl = ALU_CTRL_W'(1);
                    6'h22: w_dec.alu_ctrl = ALU_CTRL_W'(2);
                    6'h23: w_dec.alu_ctrl = ALU_CTRL_W'(3);
                    6'h24: w_dec.alu_ctrl = ALU_CTRL_W'(4);
                    6'h27: w_dec.alu_ctrl = ALU_CTRL_W'(5);
                    6'h25: w_dec.alu_ctrl = ALU_CTRL_W'(6);
                    6'h26: w_dec.alu_ctrl = ALU_CTRL_W'(7);
                    6'h00: begin w_dec.alu_ctrl = ALU_CTRL_W'(8);  w_dec.shamt = 1'b1; end
                    6'h04: w_dec.alu_ctrl = ALU_CTRL_W'(9);
                    6'h02: begin w_dec.alu_ctrl = ALU_CTRL_W'(10); w_dec.shamt = 1'b1; end
                    6'h06: w_dec.alu_ctrl = ALU_CTRL_W'(11);
                    6'h03: begin w_dec.alu_ctrl = ALU_CTRL_W'(12); w_dec.shamt = 1'b1; end
                    6'h07: w_dec.alu_ctrl = ALU_CTRL_W'(13);
                    6'h2A: w_dec.alu_ctrl = ALU_CTRL_W'(14);
                    6'h08: begin
                        // jr writes no register
                        w_dec.alu_ctrl  = ALU_CTRL_W'(15);
                        w_dec.reg_write = 1'b0;
                        w_dec.pc_sel    = 3'd3;
                    end
                    default: begin
                        w_dec         = '0;
                        w_dec.illegal = 1'b1;
                    end
                endcase
            end
            6'h08: begin w_dec.alu_ctrl = ALU_CTRL_W'(16); w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.sign_ext = 1'b1; end
            6'h09: begin w_dec.alu_ctrl = ALU_CTRL_W'(17); w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.sign_ext = 1'b1; end
            6'h0C: begin w_dec.alu_ctrl = ALU_CTRL_W'(18); w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; end
            6'h0D: begin w_dec.alu_ctrl = ALU_CTRL_W'(19); w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; end
            6'h0E: begin w_dec.alu_ctrl = ALU_CTRL_W'(20); w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; end
            6'h04: begin w_dec.alu_ctrl = ALU_CTRL_W'(21); w_dec.branch = 1'b1; w_dec.sign_ext = 1'b1; w_dec.pc_sel = 3'd2; end
            6'h05: begin w_dec.alu_ctrl = ALU_CTRL_W'(22); w_dec.branch = 1'b1; w_dec.sign_ext = 1'b1; w_dec.pc_sel = 3'd2; end
            6'h23: begin
                w_dec.alu_ctrl   = ALU_CTRL_W'(23);
                w_dec.reg_write  = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.mem_read   = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.sign_ext   = 1'b1;
            end
            6'h2B: begin
                w_dec.alu_ctrl  = ALU_CTRL_W'(24);
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.sign_ext  = 1'b1;
                w_dec.sw        = 1'b1;
            end
            6'h02: begin w_dec.alu_ctrl = ALU_CTRL_W'(25); w_dec.pc_sel = 3'd1; end
            6'h03: begin w_dec.alu_ctrl = ALU_CTRL_W'(26); w_dec.pc_sel = 3'd1; w_dec.reg_write = 1'b1; end
            default: w_dec.illegal = 1'b1;
        endcase
    end

    // Load-use hazard. Only instructions that read rt as a source (R-type,
    // beq/bne, sw) compare against rt. A bubble has all fields zero, so it
    // never matches.
    assign w_uses_rt = w_dec.r_type | w_dec.branch | w_dec.sw;
    assign w_hazard  = valid_d & r_valid_e & r_e.mem_read & (r_rt_e != '0) &
                       ((r_rt_e == w_rs_d) | (w_uses_rt & (r_rt_e == w_rt_d)));

    assign stall_fd = freeze | ((r_state == ST_RUN) & w_hazard) | (r_state == ST_STALL);

    // Next-state logic for the bubble FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_dec  = 1'b0;
        if (freeze) begin
            w_state_nxt = r_state;
        end else if (flush_e) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_STALL) begin
            if (r_cnt <= 3'd1) begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt - 3'd1;
            end
        end else if (w_hazard) begin
            // The hazard cycle itself is the first bubble.
            if (LOAD_DELAY > 1) begin
                w_state_nxt = ST_STALL;
                w_cnt_nxt   = 3'(LOAD_DELAY - 1);
            end
        end else begin
            w_load_dec = valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ID/EX register and the undefined-instruction accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e          <= '0;
            r_valid_e    <= 1'b0;
            r_rs_e       <= '0;
            r_rt_e       <= '0;
            r_rd_e       <= '0;
            r_ill_sticky <= 1'b0;
            r_ill_cnt    <= '0;
        end else if (!freeze) begin
            if (w_load_dec) begin
                r_e       <= w_dec;
                r_valid_e <= 1'b1;
                r_rs_e    <= w_rs_d;
                r_rt_e    <= w_rt_d;
                r_rd_e    <= w_rd_d;
                if (w_dec.illegal) begin
                    r_ill_sticky <= 1'b1;
                    if (r_ill_cnt != '1) begin
                        r_ill_cnt <= r_ill_cnt + 1'b1;
                    end
                end
            end else begin
                r_e       <= '0;
                r_valid_e <= 1'b0;
                r_rs_e    <= '0;
                r_rt_e    <= '0;
                r_rd_e    <= '0;
            end
        end
    end

    assign valid_e      = r_valid_e;
    assign reg_write_e  = r_e.reg_write;
    assign mem_to_reg_e = r_e.mem_to_reg;
    assign mem_write_e  = r_e.mem_write;
    assign mem_read_e   = r_e.mem_read;
    assign branch_e     = r_e.branch;
    assign alu_src_e    = r_e.alu_src;
    assign reg_dst_e    = r_e.reg_dst;
    assign sign_ext_e   = r_e.sign_ext;
    assign shamt_e      = r_e.shamt;
    assign r_type_e     = r_e.r_type;
    assign sw_e         = r_e.sw;
    assign pc_sel_e     = r_e.pc_sel;
    assign alu_ctrl_e   = r_e.alu_ctrl;
    assign illegal_e    = r_e.illegal;
    assign rs_e         = r_rs_e;
    assign rt_e         = r_rt_e;
    assign rd_e         = r_rd_e;
    assign ill_sticky   = r_ill_sticky;
    assign ill_cnt      = r_ill_cnt;

endmodule
